// File: rtl/lsu_fsm.sv
// Multi-cycle load/store unit: one access at a time, byte-strobed word requests, response watchdog.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module lsu_fsm #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   state_t      state_r;
   state_t      state_nxt_s;
   logic        we_r;
   logic [2:0]  op_r;
   logic [31:0] addr_r;
   logic [3:0]  wstrb_r;
   logic [31:0] wdata_r;
   logic [15:0] cnt_r;
   logic [31:0] rdata_r;
   logic        err_r;
   logic        fault_s;

   function automatic logic bad_op_f(input logic [2:0] op);
      case (op)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_op_f = 1'b0;
         default:                                bad_op_f = 1'b1;
      endcase
   endfunction

   function automatic logic misalign_f(input logic [2:0] op, input logic [1:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      case (op[1:0])
         2'b01:   misalign_f = a[0];
         2'b10:   misalign_f = (a != 2'b00);
         default: misalign_f = 1'b0;
      endcase
`else
      misalign_f = 1'b0 & (^{op, a});
`endif
   endfunction

   function automatic logic [3:0] strb_f(input logic [2:0] op, input logic [1:0] a);
      case (op[1:0])
         2'b00:   strb_f = 4'b0001 << a;
         2'b01:   strb_f = 4'b0011 << {a[1], 1'b0};
         2'b10:   strb_f = 4'b1111;
         default: strb_f = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] wdata_f(input logic [2:0] op, input logic [31:0] wd);
      case (op[1:0])
         2'b00:   wdata_f = {4{wd[7:0]}};
         2'b01:   wdata_f = {2{wd[15:0]}};
         default: wdata_f = wd;
      endcase
   endfunction

   // Lane shift then sign-extend (op[2]=0) or zero-fill (op[2]=1)
   function automatic logic [31:0] load_f(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] rd);
      logic [31:0] sh;
      case (op[1:0])
         2'b00: begin
            sh     = rd >> {a, 3'b000};
            load_f = {{24{~op[2] & sh[7]}}, sh[7:0]};
         end
         2'b01: begin
            sh     = rd >> {a[1], 4'b0000};
            load_f = {{16{~op[2] & sh[15]}}, sh[15:0]};
         end
         default: begin
            sh     = rd;
            load_f = sh;
         end
      endcase
   endfunction

   assign fault_s = bad_op_f(req_op) | misalign_f(req_op, req_addr[1:0]);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               state_nxt_s = fault_s ? RESP : ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (mem_gnt) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         WAIT: begin
            if (mem_rvalid || (cnt_r == TIMEOUT_C)) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Request capture, watchdog and response latching
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r    <= 1'b0;
         op_r    <= 3'b000;
         addr_r  <= 32'h0000_0000;
         wstrb_r <= 4'b0000;
         wdata_r <= 32'h0000_0000;
         cnt_r   <= 16'h0000;
         rdata_r <= 32'h0000_0000;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  we_r    <= req_we;
                  op_r    <= req_op;
                  addr_r  <= req_addr;
                  wstrb_r <= req_we ? strb_f(req_op, req_addr[1:0]) : 4'b0000;
                  wdata_r <= req_we ? wdata_f(req_op, req_wdata) : 32'h0000_0000;
                  err_r   <= fault_s;
                  rdata_r <= 32'h0000_0000;
               end
            end
            ISSUE: begin
               if (mem_gnt) begin
                  cnt_r <= 16'h0000;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  err_r   <= 1'b0;
                  rdata_r <= we_r ? 32'h0000_0000 : load_f(op_r, addr_r[1:0], mem_rdata);
               end else if (cnt_r == TIMEOUT_C) begin
                  err_r   <= 1'b1;
                  rdata_r <= 32'h0000_0000;
               end else begin
                  cnt_r <= cnt_r + 16'h0001;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Outputs decode the state register so reset drops them immediately
   assign req_ready  = (state_r == IDLE);
   assign resp_valid = (state_r == RESP);
   assign resp_rdata = resp_valid ? rdata_r : 32'h0000_0000;
   assign resp_err   = resp_valid & err_r;
   assign mem_req    = (state_r == ISSUE);
   assign mem_we     = mem_req & we_r;
   assign mem_addr   = mem_req ? {addr_r[31:2], 2'b00} : 32'h0000_0000;
   assign mem_wstrb  = mem_req ? wstrb_r : 4'b0000;
   assign mem_wdata  = mem_req ? wdata_r : 32'h0000_0000;

endmodule

// File: tb/tb_lsu_fsm.sv
// Directed self-checking bench for lsu_fsm (TIMEOUT=4), covering loads, stores, stalls, timeout and faults.
module tb_lsu_fsm;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_gnt, mem_we, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   int          n_chk = 0;
   int          n_err = 0;

   lsu_fsm #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic we, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
      chk("ready_before_req", req_ready, 32'd1);
      req_valid = 1'b1; req_we = we; req_op = op; req_addr = a; req_wdata = wd;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, req_ready, 32'd1);
      chk({tag, "_rvalid"}, resp_valid, 32'd0);
      chk({tag, "_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_err"}, resp_err, 32'd0);
      chk({tag, "_mreq"}, mem_req, 32'd0);
      chk({tag, "_mwe"}, mem_we, 32'd0);
      chk({tag, "_maddr"}, mem_addr, 32'd0);
      chk({tag, "_mstrb"}, mem_wstrb, 32'd0);
      chk({tag, "_mwdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      #2;
      chk_idle_outputs("reset");
      #10 rst_n = 1'b1;
      tick();

      // Load byte signed, best-case timing
      accept(1'b0, 3'b000, 32'h8000_0003, 32'h0);
      chk("lb_mreq", mem_req, 32'd1);
      chk("lb_ready_low", req_ready, 32'd0);
      chk("lb_maddr", mem_addr, 32'h8000_0000);
      chk("lb_mstrb", mem_wstrb, 32'h0);
      chk("lb_mwe", mem_we, 32'd0);
      mem_gnt = 1'b1;
      tick();
      chk("lb_wait_mreq", mem_req, 32'd0);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80AB_CDEF;
      tick();
      mem_rvalid = 1'b0;
      chk("lb_rvalid", resp_valid, 32'd1);
      chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
      chk("lb_err", resp_err, 32'd0);
      tick();
      chk("lb_resp_one_cycle", resp_valid, 32'd0);

      // Store half at offset 2
      accept(1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678);
      chk("sh_mwe", mem_we, 32'd1);
      chk("sh_mstrb", mem_wstrb, 32'hC);
      chk("sh_mwdata", mem_wdata, 32'h5678_5678);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      chk("sh_rvalid", resp_valid, 32'd1);
      chk("sh_rdata", resp_rdata, 32'h0);
      chk("sh_err", resp_err, 32'd0);
      tick();

      // Store byte at offset 1
      accept(1'b1, 3'b100, 32'h0000_0101, 32'h0000_00A5);
      chk("sb_mstrb", mem_wstrb, 32'h2);
      chk("sb_mwdata", mem_wdata, 32'hA5A5_A5A5);
      chk("sb_maddr", mem_addr, 32'h0000_0100);
      mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
      mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
      chk("sb_rvalid", resp_valid, 32'd1);
      tick();

      // Grant withheld five cycles, load half unsigned at offset 2
      accept(1'b0, 3'b101, 32'h8000_0002, 32'h0);
      for (int i = 0; i < 6; i++) begin
         chk("stall_mreq", mem_req, 32'd1);
         chk("stall_maddr", mem_addr, 32'h8000_0000);
         chk("stall_mstrb", mem_wstrb, 32'h0);
         chk("stall_mwe", mem_we, 32'd0);
         if (i == 5) mem_gnt = 1'b1;
         tick();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
      tick();
      mem_rvalid = 1'b0;
      chk("lhu_rdata", resp_rdata, 32'h0000_BEEF);
      chk("lhu_err", resp_err, 32'd0);
      tick();

      // Load half signed at offset 0
      accept(1'b0, 3'b001, 32'h0000_0010, 32'h0);
      mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_9ABC; tick(); mem_rvalid = 1'b0;
      chk("lh_rdata", resp_rdata, 32'hFFFF_9ABC);
      tick();

      // Watchdog timeout with TIMEOUT=4
      accept(1'b0, 3'b010, 32'h8000_0000, 32'h0);
      mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("to_no_resp", resp_valid, 32'd0);
         tick();
      end
      chk("to_rvalid", resp_valid, 32'd1);
      chk("to_err", resp_err, 32'd1);
      chk("to_rdata", resp_rdata, 32'h0);
      tick();
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      mem_rvalid = 1'b0;
      chk("late_rvalid_resp", resp_valid, 32'd0);
      chk("late_rvalid_ready", req_ready, 32'd1);
      chk("late_rvalid_mreq", mem_req, 32'd0);

      // Word load at misaligned address
      accept(1'b0, 3'b010, 32'h8000_0001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_rvalid", resp_valid, 32'd1);
      chk("mis_err", resp_err, 32'd1);
      chk("mis_mreq", mem_req, 32'd0);
      tick();
`else
      chk("mis_maddr", mem_addr, 32'h8000_0000);
      chk("mis_mreq", mem_req, 32'd1);
      mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344; tick(); mem_rvalid = 1'b0;
      chk("mis_rdata", resp_rdata, 32'h1122_3344);
      chk("mis_err", resp_err, 32'd0);
      tick();
`endif

      // Unsupported op
      accept(1'b0, 3'b111, 32'h0000_0000, 32'h0);
      chk("badop_rvalid", resp_valid, 32'd1);
      chk("badop_err", resp_err, 32'd1);
      chk("badop_mreq", mem_req, 32'd0);
      chk("badop_rdata", resp_rdata, 32'h0);
      tick();

      // Asynchronous reset while in WAIT
      accept(1'b0, 3'b010, 32'h0000_0040, 32'h0);
      mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
      chk("rst_pre_ready", req_ready, 32'd0);
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("rst_wait");
      #1 rst_n = 1'b1;
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
      tick();
      mem_rvalid = 1'b0;
      chk("post_rst_resp", resp_valid, 32'd0);
      chk("post_rst_ready", req_ready, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
